// File: rtl/uart_program_loader.sv
// Receives a program over an 8N1 serial line and writes it as 12-bit words into main memory.
// Frame: 2-byte word count N (low, high[3:0]), then N words sent as low byte / high byte[3:0].
module uart_program_loader #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115_200,
  parameter int MEM_SIZE = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rxd,
  input  logic        i_load_en,
  output logic [11:0] o_mem_addr,
  output logic        o_mem_write_enable,
  output logic [11:0] o_mem_data_in,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_frame_error,
  output logic        o_overflow
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [12:0] MEM_SIZE_W = 13'(MEM_SIZE);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_CNT_LO, L_CNT_HI, L_W_LO, L_W_HI, L_WRITE, L_DONE} ld_state_t;

  rx_state_t     r_rx_state;
  ld_state_t     r_ld_state;
  logic          r_rxd_s1, r_rxd_s2, r_rxd_prev;
  logic [CW-1:0] r_bit_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_rx_byte;
  logic          r_byte_valid;
  logic          r_rx_ferr;
  logic          r_load_prev;
  logic [11:0]   r_n;
  logic [11:0]   r_addr;
  logic [7:0]    r_data_lo;
  logic          w_start_edge;
  logic          w_load_rise;

  assign w_start_edge = r_rxd_prev & ~r_rxd_s2;
  assign w_load_rise  = i_load_en & ~r_load_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rxd_s1   <= 1'b1;
      r_rxd_s2   <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_s1   <= i_rxd;
      r_rxd_s2   <= r_rxd_s1;
      r_rxd_prev <= r_rxd_s2;
    end
  end

  // Receiver: bit timer is a down-counter, sampling on terminal count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_state   <= RX_IDLE;
      r_bit_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_rx_byte    <= '0;
      r_byte_valid <= 1'b0;
      r_rx_ferr    <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_rx_ferr    <= 1'b0;
      case (r_rx_state)
        RX_IDLE: if (w_start_edge) begin
          r_rx_state <= RX_START;
          r_bit_cnt  <= HALF_RELOAD;
        end
        RX_START: if (r_bit_cnt == '0) begin
          r_bit_cnt  <= BIT_RELOAD;
          r_bit_idx  <= '0;
          r_rx_state <= r_rxd_s2 ? RX_IDLE : RX_DATA;
        end else r_bit_cnt <= r_bit_cnt - 1'b1;
        RX_DATA: if (r_bit_cnt == '0) begin
          r_shift   <= {r_rxd_s2, r_shift[7:1]};
          r_bit_cnt <= BIT_RELOAD;
          r_bit_idx <= r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
        end else r_bit_cnt <= r_bit_cnt - 1'b1;
        RX_STOP: if (r_bit_cnt == '0) begin
          if (r_rxd_s2) begin
            r_rx_byte    <= r_shift;
            r_byte_valid <= 1'b1;
          end else r_rx_ferr <= 1'b1;
          r_rx_state <= RX_IDLE;
        end else r_bit_cnt <= r_bit_cnt - 1'b1;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ld_state         <= L_IDLE;
      r_load_prev        <= 1'b0;
      r_n                <= '0;
      r_addr             <= '0;
      r_data_lo          <= '0;
      o_mem_addr         <= '0;
      o_mem_write_enable <= 1'b0;
      o_mem_data_in      <= '0;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
      o_frame_error      <= 1'b0;
      o_overflow         <= 1'b0;
    end else begin
      r_load_prev        <= i_load_en;
      o_mem_write_enable <= 1'b0;
      if (r_rx_ferr && o_busy) o_frame_error <= 1'b1;
      if (!i_load_en && r_ld_state != L_IDLE) begin
        // Abort (or leave DONE): done keeps whatever value it had.
        r_ld_state <= L_IDLE;
        o_busy     <= 1'b0;
      end else begin
        case (r_ld_state)
          L_IDLE: if (w_load_rise) begin
            r_ld_state    <= L_CNT_LO;
            o_busy        <= 1'b1;
            o_done        <= 1'b0;
            o_frame_error <= 1'b0;
            o_overflow    <= 1'b0;
            r_addr        <= '0;
          end
          L_CNT_LO: if (r_byte_valid) begin
            r_n[7:0]   <= r_rx_byte;
            r_ld_state <= L_CNT_HI;
          end
          L_CNT_HI: if (r_byte_valid) begin
            r_n[11:8]  <= r_rx_byte[3:0];
            o_overflow <= {1'b0, r_rx_byte[3:0], r_n[7:0]} > MEM_SIZE_W;
            if ({r_rx_byte[3:0], r_n[7:0]} == 12'd0) begin
              r_ld_state <= L_DONE;
              o_busy     <= 1'b0;
              o_done     <= 1'b1;
            end else r_ld_state <= L_W_LO;
          end
          L_W_LO: if (r_byte_valid) begin
            r_data_lo  <= r_rx_byte;
            r_ld_state <= L_W_HI;
          end
          L_W_HI: if (r_byte_valid) begin
            if ({1'b0, r_addr} < MEM_SIZE_W) begin
              o_mem_addr         <= r_addr;
              o_mem_data_in      <= {r_rx_byte[3:0], r_data_lo};
              o_mem_write_enable <= 1'b1;
            end
            r_ld_state <= L_WRITE;
          end
          L_WRITE: begin
            r_addr <= r_addr + 12'd1;
            if (r_addr + 12'd1 == r_n) begin
              r_ld_state <= L_DONE;
              o_busy     <= 1'b0;
              o_done     <= 1'b1;
            end else r_ld_state <= L_W_LO;
          end
          L_DONE: r_ld_state <= L_DONE;
          default: r_ld_state <= L_IDLE;
        endcase
      end
    end
  end

endmodule
